// File: rtl/simd_pipe_ctrl.sv
// Load/execute/store control pipeline: tracks each accepted instruction through
// LOAD_LAT + EXEC_LAT + 1 slots with RAW interlock and an IDLE/RUN/DRAIN/DONE run sequence.
module simd_pipe_ctrl #(
  parameter int ADDR_WIDTH     = 10,
  parameter int INS_ADDR_WIDTH = 8,
  parameter int OP_SEL_WIDTH   = 3,
  parameter int DOT_CTRL_WIDTH = 2,
  parameter int LOAD_LAT       = 1,
  parameter int EXEC_LAT       = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      stall,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic                      dec_halt,
  input  logic [ADDR_WIDTH-1:0]     dec_a_addr,
  input  logic [ADDR_WIDTH-1:0]     dec_b_addr,
  input  logic [ADDR_WIDTH-1:0]     dec_r_addr,
  input  logic [OP_SEL_WIDTH-1:0]   dec_op,
  input  logic [DOT_CTRL_WIDTH-1:0] dec_dot,
  input  logic                      dec_wen,
  input  logic                      dec_rsel,
  output logic [INS_ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0]     bram_a_addr,
  output logic [ADDR_WIDTH-1:0]     bram_b_addr,
  output logic                      exec_valid,
  output logic [OP_SEL_WIDTH-1:0]   exec_op,
  output logic [DOT_CTRL_WIDTH-1:0] exec_dot,
  output logic [ADDR_WIDTH-1:0]     bram_r_addr,
  output logic                      bram_r_wen,
  output logic                      r_sel,
  output logic                      hazard,
  output logic                      busy,
  output logic                      done
);

  localparam int D = LOAD_LAT + EXEC_LAT + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state_q;
  logic [INS_ADDR_WIDTH-1:0] pc_q;
  logic [D-1:0]              valid_q;
  logic [D-1:0]              wen_q;
  logic [D-1:0]              rsel_q;
  logic [ADDR_WIDTH-1:0]     a_q   [D];
  logic [ADDR_WIDTH-1:0]     b_q   [D];
  logic [ADDR_WIDTH-1:0]     r_q   [D];
  logic [OP_SEL_WIDTH-1:0]   op_q  [D];
  logic [DOT_CTRL_WIDTH-1:0] dot_q [D];

  logic hazard_match;
  logic run_active;
  logic accept;
  logic issue;

  // A pending write in any slot blocks a reader of that address until it retires.
  always_comb begin
    hazard_match = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (valid_q[i] && wen_q[i] &&
          ((r_q[i] == dec_a_addr) || (r_q[i] == dec_b_addr)))
        hazard_match = 1'b1;
    end
    hazard_match = hazard_match & dec_valid & ~dec_halt;
  end

  assign run_active = (state_q == RUN) & ~stall;
  assign dec_ready  = run_active & ~hazard_match;
  assign hazard     = run_active & hazard_match;
  assign accept     = dec_valid & dec_ready;
  assign issue      = accept & ~dec_halt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      valid_q <= '0;
      wen_q   <= '0;
      rsel_q  <= '0;
      for (int i = 0; i < D; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        r_q[i]   <= '0;
        op_q[i]  <= '0;
        dot_q[i] <= '0;
      end
    end else if (!stall) begin
      for (int i = D-1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
        wen_q[i]   <= wen_q[i-1];
        rsel_q[i]  <= rsel_q[i-1];
        a_q[i]     <= a_q[i-1];
        b_q[i]     <= b_q[i-1];
        r_q[i]     <= r_q[i-1];
        op_q[i]    <= op_q[i-1];
        dot_q[i]   <= dot_q[i-1];
      end
      valid_q[0] <= issue;
      if (issue) begin
        wen_q[0]  <= dec_wen;
        rsel_q[0] <= dec_rsel;
        a_q[0]    <= dec_a_addr;
        b_q[0]    <= dec_b_addr;
        r_q[0]    <= dec_r_addr;
        op_q[0]   <= dec_op;
        dot_q[0]  <= dec_dot;
      end

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            pc_q    <= '0;
            valid_q <= '0;
          end
        end
        RUN: begin
          if (accept && dec_halt)
            state_q <= DRAIN;
          if (issue)
            pc_q <= pc_q + INS_ADDR_WIDTH'(1);
        end
        DRAIN: begin
          if (valid_q == '0)
            state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc          = pc_q;
  assign bram_a_addr = a_q[0];
  assign bram_b_addr = b_q[0];
  assign exec_valid  = valid_q[LOAD_LAT];
  assign exec_op     = op_q[LOAD_LAT];
  assign exec_dot    = dot_q[LOAD_LAT];
  assign bram_r_addr = r_q[D-1];
  assign r_sel       = rsel_q[D-1];
  // A store frozen by stall is held in the last slot and written once stall drops.
  assign bram_r_wen  = valid_q[D-1] & wen_q[D-1] & ~stall;
  assign busy        = (state_q == RUN) | (state_q == DRAIN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_simd_pipe_ctrl.sv
// Randomised scoreboard bench for simd_pipe_ctrl: the driver queues expected
// load/exec/store events per accepted instruction, a negedge monitor checks them.
module tb_simd_pipe_ctrl;

  localparam int AW = 10;
  localparam int IW = 8;
  localparam int OW = 3;
  localparam int DW = 2;
  localparam int LL = 1;
  localparam int EL = 2;
  localparam int D  = LL + EL + 1;

  logic          clk, rstn, start, stall;
  logic          dec_valid, dec_ready, dec_halt, dec_wen, dec_rsel;
  logic [AW-1:0] dec_a_addr, dec_b_addr, dec_r_addr;
  logic [OW-1:0] dec_op;
  logic [DW-1:0] dec_dot;
  logic [IW-1:0] pc;
  logic [AW-1:0] bram_a_addr, bram_b_addr, bram_r_addr;
  logic          exec_valid, bram_r_wen, r_sel, hazard, busy, done;
  logic [OW-1:0] exec_op;
  logic [DW-1:0] exec_dot;

  simd_pipe_ctrl #(
    .ADDR_WIDTH(AW), .INS_ADDR_WIDTH(IW), .OP_SEL_WIDTH(OW),
    .DOT_CTRL_WIDTH(DW), .LOAD_LAT(LL), .EXEC_LAT(EL)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .stall(stall),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_halt(dec_halt),
    .dec_a_addr(dec_a_addr), .dec_b_addr(dec_b_addr), .dec_r_addr(dec_r_addr),
    .dec_op(dec_op), .dec_dot(dec_dot), .dec_wen(dec_wen), .dec_rsel(dec_rsel),
    .pc(pc), .bram_a_addr(bram_a_addr), .bram_b_addr(bram_b_addr),
    .exec_valid(exec_valid), .exec_op(exec_op), .exec_dot(exec_dot),
    .bram_r_addr(bram_r_addr), .bram_r_wen(bram_r_wen), .r_sel(r_sel),
    .hazard(hazard), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            t;
    logic [AW-1:0] a, b, r;
    logic [OW-1:0] op;
    logic [DW-1:0] dot;
    logic          rsel;
  } ins_t;

  ins_t          ld_q[$];
  ins_t          ex_q[$];
  ins_t          wr_q[$];
  int            tick = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            hz_count = 0;
  bit            model_run = 0;
  bit            exp_hz;
  logic [IW-1:0] model_pc = '0;
  ins_t          m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tick);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (tick %0d)", name, tick);
  endtask

  // Tick counts clock edges at which the pipeline is allowed to advance.
  always @(posedge clk) if (!stall) tick <= tick + 1;

  always @(negedge clk) begin
    if (rstn) begin
      if (stall) begin
        chk("stall_wen", bram_r_wen, 0);
        chk("stall_ready", dec_ready, 0);
        chk("stall_hazard", hazard, 0);
      end else begin
        if (hazard) hz_count++;
        if (model_run && dec_valid && !dec_halt) begin
          exp_hz = 1'b0;
          foreach (wr_q[i])
            if (wr_q[i].t <= tick && tick <= wr_q[i].t + D - 1 &&
                (wr_q[i].r == dec_a_addr || wr_q[i].r == dec_b_addr))
              exp_hz = 1'b1;
          chk("hazard", hazard, exp_hz);
          chk("dec_ready", dec_ready, !exp_hz);
        end
        if (ld_q.size() > 0 && ld_q[0].t <= tick) begin
          m = ld_q.pop_front();
          chk("load_tick", tick, m.t);
          chk("load_a", bram_a_addr, m.a);
          chk("load_b", bram_b_addr, m.b);
        end
        if (exec_valid) begin
          if (ex_q.size() == 0) fail_now("exec_unexpected");
          else begin
            m = ex_q.pop_front();
            chk("exec_tick", tick, m.t + LL);
            chk("exec_op", exec_op, m.op);
            chk("exec_dot", exec_dot, m.dot);
          end
        end else if (ex_q.size() > 0 && ex_q[0].t + LL <= tick) begin
          m = ex_q.pop_front();
          fail_now("exec_missing");
        end
        if (bram_r_wen) begin
          if (wr_q.size() == 0) fail_now("write_unexpected");
          else begin
            m = wr_q.pop_front();
            $display("write r=%0d rsel=%0d tick=%0d", bram_r_addr, r_sel, tick);
            chk("write_tick", tick, m.t + D - 1);
            chk("write_addr", bram_r_addr, m.r);
            chk("write_rsel", r_sel, m.rsel);
          end
        end else if (wr_q.size() > 0 && wr_q[0].t + D - 1 <= tick) begin
          m = wr_q.pop_front();
          fail_now("write_missing");
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_run = 1'b1;
    model_pc = '0;
  endtask

  // Presents one instruction; called at posedge+1 and returns at posedge+1 after acceptance.
  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] r,
                       input logic [OW-1:0] op, input logic [DW-1:0] dot, input logic wen,
                       input logic rsel, input logic halt, output int acc);
    bit   got;
    ins_t e;
    got = 1'b0;
    acc = -1;
    dec_valid = 1'b1; dec_halt = halt;
    dec_a_addr = a; dec_b_addr = b; dec_r_addr = r;
    dec_op = op; dec_dot = dot; dec_wen = wen; dec_rsel = rsel;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (dec_ready) begin
        got = 1'b1;
        acc = tick + 1;
        if (!halt) begin
          e.t = acc; e.a = a; e.b = b; e.r = r; e.op = op; e.dot = dot; e.rsel = rsel;
          ld_q.push_back(e);
          ex_q.push_back(e);
          if (wen) wr_q.push_back(e);
          model_pc = model_pc + 1'b1;
        end else begin
          model_run = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
    dec_valid = 1'b0;
    dec_halt = 1'b0;
    if (!got) fail_now("issue_timeout");
    else begin
      $display("issue a=%0d b=%0d r=%0d halt=%0d tick=%0d pc=%0d", a, b, r, halt, acc, pc);
      if (!halt) chk("pc", pc, model_pc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_dec_ready"}, dec_ready, 0);
    chk({tag, "_bram_a"}, bram_a_addr, 0);
    chk({tag, "_bram_b"}, bram_b_addr, 0);
    chk({tag, "_exec_valid"}, exec_valid, 0);
    chk({tag, "_exec_op"}, exec_op, 0);
    chk({tag, "_exec_dot"}, exec_dot, 0);
    chk({tag, "_bram_r"}, bram_r_addr, 0);
    chk({tag, "_wen"}, bram_r_wen, 0);
    chk({tag, "_rsel"}, r_sel, 0);
    chk({tag, "_hazard"}, hazard, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  int acc [4];
  int acc0, acc1, pc_before;
  bit seen_done;

  initial begin
    rstn = 1'b0; start = 1'b0; stall = 1'b0;
    dec_valid = 1'b0; dec_halt = 1'b0; dec_wen = 1'b0; dec_rsel = 1'b0;
    dec_a_addr = '0; dec_b_addr = '0; dec_r_addr = '0; dec_op = '0; dec_dot = '0;
    idle(3);
    rstn = 1'b1;
    check_zero("reset");

    // Four independent instructions issue on consecutive cycles.
    do_start();
    chk("busy_after_start", busy, 1);
    for (int k = 0; k < 4; k++) begin
      issue(AW'(k + 1), AW'(k + 11), AW'(k + 21), OW'(k), DW'(k), 1'b1, k[0], 1'b0, acc[k]);
      if (k > 0) chk("back_to_back", acc[k] - acc[k-1], 1);
    end
    chk("pc_after_4", pc, 4);
    idle(D + 2);

    // RAW pair: consumer waits D bubbles after the producer.
    issue(10'd30, 10'd31, 10'd50, 3'd1, 2'd1, 1'b1, 1'b0, 1'b0, acc0);
    hz_count = 0;
    issue(10'd50, 10'd32, 10'd51, 3'd2, 2'd2, 1'b1, 1'b1, 1'b0, acc1);
    chk("raw_gap", acc1 - acc0, D + 1);
    chk("raw_hazard_cycles", hz_count, D);
    idle(D + 2);

    // Stall while a write sits in the store stage.
    issue(10'd40, 10'd41, 10'd60, 3'd3, 2'd3, 1'b1, 1'b1, 1'b0, acc0);
    idle(D - 1);
    pc_before = pc;
    stall = 1'b1;
    idle(3);
    chk("stall_pc", pc, pc_before);
    stall = 1'b0;
    idle(D + 1);
    chk("stall_writes_retired", wr_q.size(), 0);

    // HALT after two instructions, then restart.
    issue(10'd80, 10'd81, 10'd70, 3'd4, 2'd0, 1'b1, 1'b0, 1'b0, acc0);
    issue(10'd82, 10'd83, 10'd71, 3'd5, 2'd1, 1'b1, 1'b1, 1'b0, acc1);
    issue(10'd0, 10'd0, 10'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, acc0);
    chk("halt_pc", pc, model_pc);
    seen_done = 1'b0;
    for (int c = 0; c < D + 2 && !seen_done; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("done_after_halt", done, 1);
    chk("busy_after_halt", busy, 0);
    chk("halt_writes_retired", wr_q.size(), 0);
    idle(2);
    chk("done_holds", done, 1);
    do_start();
    chk("restart_pc", pc, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);

    // 256 random instructions over a small address range: pc wraps, hazards occur.
    for (int n = 0; n < 256; n++) begin
      issue(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
            OW'($urandom_range(0, 7)), DW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0, acc0);
    end
    chk("pc_wrap", pc, 0);
    idle(D + 2);
    chk("wrap_writes_retired", wr_q.size(), 0);

    // Reset with three writes in flight.
    issue(10'd100, 10'd101, 10'd120, 3'd1, 2'd1, 1'b1, 1'b0, 1'b0, acc0);
    issue(10'd102, 10'd103, 10'd121, 3'd2, 2'd2, 1'b1, 1'b1, 1'b0, acc0);
    issue(10'd104, 10'd105, 10'd122, 3'd3, 2'd3, 1'b1, 1'b0, 1'b0, acc0);
    rstn = 1'b0;
    ld_q.delete(); ex_q.delete(); wr_q.delete();
    model_run = 1'b0;
    model_pc = '0;
    idle(1);
    rstn = 1'b1;
    check_zero("midreset");
    idle(D + 2);
    check_zero("after_midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
